// File: rtl/crc_pkg.sv
// Shared types and constants for the serial CRC engine family.
package crc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT_MSG,
    SHIFT_CRC,
    DONE
  } crc_state_e;

  localparam logic [8:0]  CRC9_POLY        = 9'h103;
  localparam logic [7:0]  CRC8_POLY        = 8'h07;
  localparam logic [15:0] CRC16_CCITT_POLY = 16'h1021;

  localparam logic MODE_GEN   = 1'b0;
  localparam logic MODE_CHECK = 1'b1;

endpackage

// File: rtl/crc_lfsr_step.sv
// One Galois LFSR step of a CRC: folds a single message bit into the register.
module crc_lfsr_step
  import crc_pkg::*;
#(
  parameter int               CRC_W = 9,
  parameter logic [CRC_W-1:0] POLY  = CRC9_POLY
) (
  input  logic [CRC_W-1:0] lfsr_in,
  input  logic             bit_in,
  output logic [CRC_W-1:0] lfsr_out
);

  logic fb;

  always_comb begin
    fb       = lfsr_in[CRC_W-1] ^ bit_in;
    lfsr_out = {lfsr_in[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
  end

endmodule

// File: rtl/crc_serial_engine.sv
// Bit-serial CRC generator/checker: one bit per clock, start/done handshake,
// result held on crc_out/crc_ok until the next completed operation.
module crc_serial_engine
  import crc_pkg::*;
#(
  parameter int               CRC_W     = 9,
  parameter logic [CRC_W-1:0] POLY      = CRC9_POLY,
  parameter int               MSG_W     = 10,
  parameter logic [CRC_W-1:0] INIT      = '0,
  parameter logic [CRC_W-1:0] XOR_OUT   = '0,
  parameter bit               MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             mode,
  input  logic [MSG_W-1:0] msg_in,
  input  logic [CRC_W-1:0] crc_in,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [CRC_W-1:0] crc_out,
  output logic             crc_ok
);

  localparam int               CNT_W    = $clog2(MSG_W + CRC_W + 1);
  localparam logic [CNT_W-1:0] MSG_LAST = CNT_W'(MSG_W - 1);
  localparam logic [CNT_W-1:0] CRC_LAST = CNT_W'(CRC_W - 1);

  crc_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CRC_W-1:0] lfsr_q, lfsr_d;
  logic [CRC_W-1:0] crc_sr_q, crc_sr_d;
  logic [CRC_W-1:0] crc_out_q, crc_out_d;
  logic [MSG_W-1:0] msg_sr_q, msg_sr_d;
  logic             mode_q, mode_d;
  logic             crc_ok_q, crc_ok_d;
  logic [CRC_W-1:0] lfsr_step;
  logic             accept, msg_bit, shift_bit;

  assign accept    = start & ready;
  assign msg_bit   = MSB_FIRST ? msg_sr_q[MSG_W-1] : msg_sr_q[0];
  assign shift_bit = (state_q == SHIFT_CRC) ? crc_sr_q[CRC_W-1] : msg_bit;

  crc_lfsr_step #(
    .CRC_W (CRC_W),
    .POLY  (POLY)
  ) u_step (
    .lfsr_in  (lfsr_q),
    .bit_in   (shift_bit),
    .lfsr_out (lfsr_step)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: state_d = start ? SHIFT_MSG : IDLE;
      SHIFT_MSG: if (cnt_q == MSG_LAST)
                   state_d = (mode_q == MODE_CHECK) ? SHIFT_CRC : DONE;
      SHIFT_CRC: if (cnt_q == CRC_LAST) state_d = DONE;
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    busy  = (state_q == SHIFT_MSG) || (state_q == SHIFT_CRC);
    ready = ~busy;
    done  = (state_q == DONE);
  end

  // Received CRC is pre-XORed so the check residue is zero for a good frame.
  always_comb begin
    cnt_d     = cnt_q;
    lfsr_d    = lfsr_q;
    msg_sr_d  = msg_sr_q;
    crc_sr_d  = crc_sr_q;
    mode_d    = mode_q;
    crc_out_d = crc_out_q;
    crc_ok_d  = crc_ok_q;
    if (accept) begin
      mode_d   = mode;
      msg_sr_d = msg_in;
      crc_sr_d = crc_in ^ XOR_OUT;
      lfsr_d   = INIT;
      cnt_d    = '0;
    end else if (busy) begin
      lfsr_d = lfsr_step;
      cnt_d  = (state_d != state_q) ? '0 : cnt_q + 1'b1;
      if (state_q == SHIFT_MSG)
        msg_sr_d = MSB_FIRST ? {msg_sr_q[MSG_W-2:0], 1'b0} : {1'b0, msg_sr_q[MSG_W-1:1]};
      else
        crc_sr_d = {crc_sr_q[CRC_W-2:0], 1'b0};
      if (state_d == DONE) begin
        crc_out_d = (mode_q == MODE_CHECK) ? lfsr_step : (lfsr_step ^ XOR_OUT);
        crc_ok_d  = (mode_q == MODE_CHECK) && (lfsr_step == '0);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q     <= '0;
      lfsr_q    <= '0;
      msg_sr_q  <= '0;
      crc_sr_q  <= '0;
      mode_q    <= 1'b0;
      crc_out_q <= '0;
      crc_ok_q  <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      lfsr_q    <= lfsr_d;
      msg_sr_q  <= msg_sr_d;
      crc_sr_q  <= crc_sr_d;
      mode_q    <= mode_d;
      crc_out_q <= crc_out_d;
      crc_ok_q  <= crc_ok_d;
    end
  end

  assign crc_out = crc_out_q;
  assign crc_ok  = crc_ok_q;

endmodule

// File: tb/tb_crc_serial_engine.sv
// Scoreboard bench for crc_serial_engine: default config, LSB-first config and a CRC-16/32-bit config.
// Latency counts clock edges from the accepting edge (counted as 1) to the edge that raises done.
`timescale 1ns/1ps
module tb_crc_serial_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset_n = 1'b1;

  logic       start0 = 1'b0, mode0 = 1'b0;
  logic [9:0] msg0 = '0;
  logic [8:0] crc0 = '0;
  logic       ready0, busy0, done0, ok0;
  logic [8:0] out0;

  logic       start1 = 1'b0, mode1 = 1'b0;
  logic [9:0] msg1 = '0;
  logic [8:0] crc1 = '0;
  logic       ready1, busy1, done1, ok1;
  logic [8:0] out1;

  logic        start2 = 1'b0, mode2 = 1'b0;
  logic [31:0] msg2 = '0;
  logic [15:0] crc2 = '0;
  logic        ready2, busy2, done2, ok2;
  logic [15:0] out2;

  crc_serial_engine u_dut0 (
    .clk(clk), .reset_n(reset_n), .start(start0), .mode(mode0), .msg_in(msg0), .crc_in(crc0),
    .ready(ready0), .busy(busy0), .done(done0), .crc_out(out0), .crc_ok(ok0)
  );

  crc_serial_engine #(.MSB_FIRST(1'b0)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .start(start1), .mode(mode1), .msg_in(msg1), .crc_in(crc1),
    .ready(ready1), .busy(busy1), .done(done1), .crc_out(out1), .crc_ok(ok1)
  );

  crc_serial_engine #(.CRC_W(16), .POLY(16'h1021), .MSG_W(32)) u_dut2 (
    .clk(clk), .reset_n(reset_n), .start(start2), .mode(mode2), .msg_in(msg2), .crc_in(crc2),
    .ready(ready2), .busy(busy2), .done(done2), .crc_out(out2), .crc_ok(ok2)
  );

  typedef struct {
    logic [31:0] crc;
    logic        ok;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int n_assert = 0;
  int n_fail   = 0;

  localparam logic [32:0] P9  = 33'h303;
  localparam logic [32:0] P16 = 33'h11021;

  // Long division of stream*x^cw by the full generator; first-shifted bit is v[len-1].
  function automatic logic [31:0] ref_rem(input logic [63:0] v, input int len, input int cw,
                                          input logic [32:0] fullp);
    logic [127:0] d;
    d = {64'd0, v} << cw;
    for (int i = len + cw - 1; i >= cw; i--)
      if (d[i]) d = d ^ ({95'd0, fullp} << (i - cw));
    return d[31:0] & ((32'd1 << cw) - 32'd1);
  endfunction

  function automatic logic [9:0] rev10(input logic [9:0] m);
    logic [9:0] r;
    for (int i = 0; i < 10; i++) r[i] = m[9-i];
    return r;
  endfunction

  task automatic go(input int which, input logic m, input logic [31:0] msg, input logic [15:0] crc);
    @(negedge clk);
    case (which)
      0:       begin start0 = 1'b1; mode0 = m; msg0 = msg[9:0]; crc0 = crc[8:0]; end
      1:       begin start1 = 1'b1; mode1 = m; msg1 = msg[9:0]; crc1 = crc[8:0]; end
      default: begin start2 = 1'b1; mode2 = m; msg2 = msg;      crc2 = crc;      end
    endcase
    @(posedge clk);
    #1;
    start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
    mode0 = ~mode0; mode1 = ~mode1; mode2 = ~mode2;
    msg0 = 10'($urandom); crc0 = 9'($urandom);
    msg1 = 10'($urandom); crc1 = 9'($urandom);
    msg2 = $urandom;      crc2 = 16'($urandom);
  endtask

  task automatic wait_done(input int which, output int lat, output bit to);
    lat = 1;
    to  = 1'b0;
    forever begin
      @(negedge clk);
      if ((which == 0 && done0 === 1'b1) || (which == 1 && done1 === 1'b1) ||
          (which == 2 && done2 === 1'b1)) return;
      lat++;
      if (lat > 200) begin
        to = 1'b1;
        return;
      end
    end
  endtask

  task automatic test_reset();
    #2 reset_n = 1'b0;
    #1;
    n_assert++; if (ready0 !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", ready0); end
    n_assert++; if (busy0 !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy0); end
    n_assert++; if (done0 !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done0); end
    n_assert++; if (out0 !== 9'h000) begin n_fail++; $display("FAIL reset_crc_out: got %h want 000", out0); end
    n_assert++; if (ok0 !== 1'b0) begin n_fail++; $display("FAIL reset_crc_ok: got %b want 0", ok0); end
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    $display("reset: ready=%b busy=%b done=%b crc_out=%h crc_ok=%b", ready0, busy0, done0, out0, ok0);
  endtask

  task automatic test_gen();
    logic [9:0] m;
    logic [8:0] x;
    exp_t e;
    int lat;
    bit to;
    for (int i = 0; i < 7; i++) begin
      case (i)
        0:       begin m = 10'h001; x = 9'h103; end
        1:       begin m = 10'h002; x = 9'h105; end
        2:       begin m = 10'h000; x = 9'h000; end
        default: begin m = 10'($urandom); x = 9'(ref_rem({54'd0, m}, 10, 9, P9)); end
      endcase
      sb.push_back('{{23'd0, x}, 1'b0, 11});
      go(0, 1'b0, {22'd0, m}, 16'd0);
      wait_done(0, lat, to);
      e = sb.pop_front();
      n_assert++;
      if (to) begin
        n_fail++; $display("FAIL gen_timeout: msg=%h no done within 200 cycles", m);
      end else begin
        if (out0 !== e.crc[8:0]) begin n_fail++; $display("FAIL gen_crc: msg=%h got %h want %h", m, out0, e.crc[8:0]); end
        n_assert++; if (ok0 !== e.ok) begin n_fail++; $display("FAIL gen_ok: msg=%h got %b want %b", m, ok0, e.ok); end
        n_assert++; if (lat != e.lat) begin n_fail++; $display("FAIL gen_latency: msg=%h got %0d want %0d", m, lat, e.lat); end
      end
      @(negedge clk);
      n_assert++; if (done0 !== 1'b0) begin n_fail++; $display("FAIL gen_done_pulse: got %b want 0", done0); end
      $display("gen msg=%h crc_out=%h crc_ok=%b latency=%0d", m, out0, ok0, lat);
    end
  endtask

  task automatic test_check();
    logic [9:0] m;
    logic [8:0] c, x;
    exp_t e;
    int lat;
    bit to;
    for (int i = 0; i < 4; i++) begin
      case (i)
        0: begin m = 10'h001; c = 9'h103; x = 9'h000; end
        1: begin m = 10'h001; c = 9'h102; x = 9'h103; end
        2: begin
          m = 10'($urandom);
          c = 9'(ref_rem({54'd0, m}, 10, 9, P9));
          x = 9'h000;
        end
        default: begin
          m = 10'($urandom);
          c = 9'(ref_rem({54'd0, m}, 10, 9, P9)) ^ 9'($urandom_range(1, 511));
          x = 9'(ref_rem({45'd0, m, c}, 19, 9, P9));
        end
      endcase
      sb.push_back('{{23'd0, x}, (x == 9'h000), 20});
      go(0, 1'b1, {22'd0, m}, {7'd0, c});
      wait_done(0, lat, to);
      e = sb.pop_front();
      n_assert++;
      if (to) begin
        n_fail++; $display("FAIL check_timeout: msg=%h crc=%h no done within 200 cycles", m, c);
      end else begin
        if (out0 !== e.crc[8:0]) begin n_fail++; $display("FAIL check_residue: msg=%h crc=%h got %h want %h", m, c, out0, e.crc[8:0]); end
        n_assert++; if (ok0 !== e.ok) begin n_fail++; $display("FAIL check_ok: msg=%h crc=%h got %b want %b", m, c, ok0, e.ok); end
        n_assert++; if (lat != e.lat) begin n_fail++; $display("FAIL check_latency: got %0d want %0d", lat, e.lat); end
      end
      $display("check msg=%h crc_in=%h crc_out=%h crc_ok=%b latency=%0d", m, c, out0, ok0, lat);
    end
  endtask

  task automatic test_busy_ignore();
    exp_t e;
    int lat, n_done;
    bit to;
    sb.push_back('{32'h103, 1'b0, 11});
    go(0, 1'b0, 32'h001, 16'd0);
    lat = 1;
    to  = 1'b0;
    forever begin
      @(negedge clk);
      start0 = (lat == 5);
      if (start0) begin msg0 = 10'h3FF; mode0 = 1'b1; end
      if (done0 === 1'b1) break;
      lat++;
      if (lat > 200) begin to = 1'b1; break; end
    end
    start0 = 1'b0;
    e = sb.pop_front();
    n_assert++;
    if (to) begin
      n_fail++; $display("FAIL busy_timeout: no done within 200 cycles");
    end else begin
      if (out0 !== e.crc[8:0]) begin n_fail++; $display("FAIL busy_crc: got %h want %h", out0, e.crc[8:0]); end
      n_assert++; if (lat != e.lat) begin n_fail++; $display("FAIL busy_latency: got %0d want %0d", lat, e.lat); end
    end
    n_done = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (done0 === 1'b1) n_done++;
    end
    n_assert++; if (n_done != 0) begin n_fail++; $display("FAIL busy_extra_done: got %0d pulses want 0", n_done); end
    n_assert++; if (out0 !== 9'h103) begin n_fail++; $display("FAIL busy_hold: got %h want 103", out0); end
    $display("busy-ignore crc_out=%h latency=%0d extra_done=%0d", out0, lat, n_done);
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int lat;
    bit to;
    sb.push_back('{32'h103, 1'b0, 11});
    go(0, 1'b0, 32'h001, 16'd0);
    wait_done(0, lat, to);
    e = sb.pop_front();
    n_assert++;
    if (to || out0 !== e.crc[8:0]) begin n_fail++; $display("FAIL b2b_first: got %h want %h timeout=%b", out0, e.crc[8:0], to); end
    n_assert++; if (ready0 !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_in_done: got %b want 1", ready0); end
    start0 = 1'b1; mode0 = 1'b0; msg0 = 10'h002;
    sb.push_back('{32'h105, 1'b0, 11});
    @(posedge clk);
    #1;
    start0 = 1'b0; msg0 = 10'h3FF;
    n_assert++; if (busy0 !== 1'b1) begin n_fail++; $display("FAIL b2b_accept: busy got %b want 1", busy0); end
    n_assert++; if (out0 !== 9'h103) begin n_fail++; $display("FAIL b2b_hold: got %h want 103", out0); end
    wait_done(0, lat, to);
    e = sb.pop_front();
    n_assert++;
    if (to) begin
      n_fail++; $display("FAIL b2b_timeout: no second done within 200 cycles");
    end else begin
      if (out0 !== e.crc[8:0]) begin n_fail++; $display("FAIL b2b_crc: got %h want %h", out0, e.crc[8:0]); end
      n_assert++; if (lat != e.lat) begin n_fail++; $display("FAIL b2b_latency: got %0d want %0d", lat, e.lat); end
    end
    $display("back-to-back second crc_out=%h latency=%0d", out0, lat);
  endtask

  task automatic test_reset_abort();
    exp_t e;
    int lat, n_done;
    bit to;
    sb.push_back('{32'h103, 1'b0, 11});
    go(0, 1'b0, 32'h001, 16'd0);
    wait_done(0, lat, to);
    e = sb.pop_front();
    n_assert++;
    if (to || out0 !== e.crc[8:0]) begin n_fail++; $display("FAIL abort_setup: got %h want %h timeout=%b", out0, e.crc[8:0], to); end
    go(0, 1'b0, 32'h002, 16'd0);
    for (int i = 0; i < 6; i++) @(negedge clk);
    n_assert++; if (busy0 !== 1'b1) begin n_fail++; $display("FAIL abort_busy_before: got %b want 1", busy0); end
    #1 reset_n = 1'b0;
    #1;
    n_assert++; if (out0 !== 9'h000) begin n_fail++; $display("FAIL abort_crc_out: got %h want 000", out0); end
    n_assert++; if (busy0 !== 1'b0 || ready0 !== 1'b1 || done0 !== 1'b0 || ok0 !== 1'b0) begin
      n_fail++; $display("FAIL abort_flags: busy=%b ready=%b done=%b ok=%b want 0 1 0 0", busy0, ready0, done0, ok0);
    end
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    n_done = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done0 === 1'b1) n_done++;
    end
    n_assert++; if (n_done != 0) begin n_fail++; $display("FAIL abort_no_done: got %0d pulses want 0", n_done); end
    sb.push_back('{32'h103, 1'b0, 11});
    go(0, 1'b0, 32'h001, 16'd0);
    wait_done(0, lat, to);
    e = sb.pop_front();
    n_assert++;
    if (to || out0 !== e.crc[8:0] || lat != e.lat) begin
      n_fail++; $display("FAIL abort_recover: got %h lat %0d want %h lat %0d timeout=%b", out0, lat, e.crc[8:0], e.lat, to);
    end
    $display("reset-abort recovered crc_out=%h latency=%0d", out0, lat);
  endtask

  task automatic test_lsb_first();
    logic [9:0] m;
    logic [8:0] x;
    exp_t e;
    int lat;
    bit to;
    for (int i = 0; i < 4; i++) begin
      if (i == 0) begin
        m = 10'h200; x = 9'h103;
      end else begin
        m = 10'($urandom); x = 9'(ref_rem({54'd0, rev10(m)}, 10, 9, P9));
      end
      sb.push_back('{{23'd0, x}, 1'b0, 11});
      go(1, 1'b0, {22'd0, m}, 16'd0);
      wait_done(1, lat, to);
      e = sb.pop_front();
      n_assert++;
      if (to) begin
        n_fail++; $display("FAIL lsb_timeout: msg=%h no done within 200 cycles", m);
      end else begin
        if (out1 !== e.crc[8:0]) begin n_fail++; $display("FAIL lsb_crc: msg=%h got %h want %h", m, out1, e.crc[8:0]); end
        n_assert++; if (lat != e.lat) begin n_fail++; $display("FAIL lsb_latency: got %0d want %0d", lat, e.lat); end
      end
      $display("lsb-first msg=%h crc_out=%h latency=%0d", m, out1, lat);
    end
  endtask

  task automatic test_crc16();
    logic [31:0] m;
    logic [15:0] c, x;
    logic        md;
    exp_t e;
    int lat;
    bit to;
    for (int i = 0; i < 6; i++) begin
      m  = $urandom;
      md = (i >= 4);
      c  = 16'(ref_rem({32'd0, m}, 32, 16, P16));
      if (i == 5) c = c ^ (16'h0001 << $urandom_range(0, 15));
      x  = md ? 16'(ref_rem({16'd0, m, c}, 48, 16, P16)) : c;
      sb.push_back('{{16'd0, x}, md && (x == 16'h0000), md ? 49 : 33});
      go(2, md, m, c);
      wait_done(2, lat, to);
      e = sb.pop_front();
      n_assert++;
      if (to) begin
        n_fail++; $display("FAIL crc16_timeout: msg=%h no done within 200 cycles", m);
      end else begin
        if ({16'd0, out2} !== e.crc) begin n_fail++; $display("FAIL crc16_crc: mode=%b msg=%h got %h want %h", md, m, out2, e.crc[15:0]); end
        n_assert++; if (ok2 !== e.ok) begin n_fail++; $display("FAIL crc16_ok: mode=%b got %b want %b", md, ok2, e.ok); end
        n_assert++; if (lat != e.lat) begin n_fail++; $display("FAIL crc16_latency: got %0d want %0d", lat, e.lat); end
      end
      $display("crc16 mode=%b msg=%h crc_in=%h crc_out=%h crc_ok=%b latency=%0d", md, m, c, out2, ok2, lat);
    end
  endtask

  initial begin
    test_reset();
    test_gen();
    test_check();
    test_busy_ignore();
    test_back_to_back();
    test_reset_abort();
    test_lsb_first();
    test_crc16();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
